// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared widths, FSM state encoding and the code-to-one-hot helper for the
// pulse decoder.
package onehot_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 1 << CODE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        return OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_fifo.sv
// Small synchronous FIFO for buffered codes. Head entry is visible on rdata
// whenever the FIFO is non-empty; flush empties it and wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Replays buffered 3-bit codes as timed one-hot pulses on Y, with an optional
// forced-zero gap between pulses.
module onehot_pulse_decoder
    import onehot_pkg::*;
#(
    parameter int HOLD       = 4,
    parameter int GAP        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [CODE_W-1:0]             in_code,
    output logic                          in_ready,
    output logic [OUT_W-1:0]              Y,
    output logic                          y_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_RLD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_RLD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OUT_W-1:0]   y_q;
    logic               y_valid_q;
    logic               rdy_q;
    logic               full, empty, pop, push;
    logic [CODE_W-1:0]  head;

    // rdy_q keeps in_ready low through reset and opens it on the first edge.
    assign in_ready = rdy_q && !full;
    assign push     = in_valid && in_ready && !flush;
    assign Y        = y_q;
    assign y_valid  = y_valid_q;
    assign busy     = (state_q != ST_IDLE) || !empty;

    always_comb begin
        pop = 1'b0;
        if (!flush && en && !empty) begin
            case (state_q)
                ST_IDLE:  pop = 1'b1;
                ST_DRIVE: pop = (cnt_q == '0) && (GAP == 0);
                default:  pop = 1'b0;
            endcase
        end
    end

    sync_fifo #(.WIDTH(CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (in_code),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (flush) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                y_q       <= '0;
                y_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pop) begin
                            state_q   <= ST_DRIVE;
                            y_q       <= onehot(head);
                            y_valid_q <= 1'b1;
                            cnt_q     <= HOLD_RLD;
                        end
                    end
                    ST_DRIVE: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (GAP > 0) begin
                            state_q   <= ST_GAP;
                            y_q       <= '0;
                            y_valid_q <= 1'b0;
                            cnt_q     <= GAP_RLD;
                        end else if (pop) begin
                            // Back-to-back: swap in the next code with no zero cycle.
                            y_q   <= onehot(head);
                            cnt_q <= HOLD_RLD;
                        end else begin
                            state_q   <= ST_IDLE;
                            y_q       <= '0;
                            y_valid_q <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == '0) state_q <= ST_IDLE;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench: HOLD=4/GAP=1 instance for most scenarios, a GAP=0 instance
// for back-to-back pulses.
module tb_onehot_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic       in_ready, y_valid, busy;
    logic [7:0] Y;
    logic [2:0] fifo_count;

    logic       en1 = 1'b0, flush1 = 1'b0, in_valid1 = 1'b0;
    logic [2:0] in_code1 = '0;
    logic       in_ready1, y_valid1, busy1;
    logic [7:0] Y1;
    logic [2:0] fifo_count1;

    int checks = 0;
    int errors = 0;
    int idx;
    logic acc;
    logic [7:0] prev_y;
    logic [7:0] got[$];
    logic [2:0] codes [5] = '{3'd0, 3'd7, 3'd2, 3'd4, 3'd1};
    logic [7:0] exp_seq [5] = '{8'h01, 8'h80, 8'h04, 8'h10, 8'h02};

    always #5 clk = ~clk;

    onehot_pulse_decoder #(.HOLD(4), .GAP(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .in_code(in_code), .in_ready(in_ready), .Y(Y), .y_valid(y_valid),
        .busy(busy), .fifo_count(fifo_count)
    );

    onehot_pulse_decoder #(.HOLD(4), .GAP(0), .FIFO_DEPTH(4)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .en(en1), .flush(flush1), .in_valid(in_valid1),
        .in_code(in_code1), .in_ready(in_ready1), .Y(Y1), .y_valid(y_valid1),
        .busy(busy1), .fifo_count(fifo_count1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values before any clock edge
        #3;
        chk("rst_Y", 32'(Y), 0);
        chk("rst_yv", 32'(y_valid), 0);
        chk("rst_cnt", 32'(fifo_count), 0);
        chk("rst_rdy", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        chk("rel_rdy0", 32'(in_ready), 0);
        tick();
        chk("rel_rdy1", 32'(in_ready), 1);

        // Single code 5
        en = 1'b1; en1 = 1'b1;
        in_valid = 1'b1; in_code = 3'd5;
        tick();
        in_valid = 1'b0;
        chk("s_cnt1", 32'(fifo_count), 1);
        chk("s_Y0", 32'(Y), 0);
        tick();
        chk("s_Y1", 32'(Y), 32'h20);
        chk("s_yv1", 32'(y_valid), 1);
        chk("s_cnt0", 32'(fifo_count), 0);
        repeat (3) begin
            tick();
            chk("s_Yhold", 32'(Y), 32'h20);
        end
        tick();
        chk("s_gapY", 32'(Y), 0);
        chk("s_gapyv", 32'(y_valid), 0);
        chk("s_gapbusy", 32'(busy), 1);
        tick();
        chk("s_idle", 32'(busy), 0);

        // Burst 0,7,2,4,1 with in_valid held
        idx = 0;
        in_valid = 1'b1; in_code = codes[0];
        prev_y = '0;
        for (int c = 0; c < 80; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 5) in_code = codes[idx];
                else begin
                    in_valid = 1'b0;
                    chk("b_rdy_full", 32'(in_ready), 0);
                    chk("b_cnt_full", 32'(fifo_count), 4);
                end
            end
            if (Y != 0 && Y != prev_y) got.push_back(Y);
            prev_y = Y;
            if (idx == 5 && !busy) break;
        end
        chk("b_pushed", 32'(idx), 5);
        chk("b_npulses", 32'(got.size()), 5);
        for (int i = 0; i < 5; i++)
            chk("b_seq", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(exp_seq[i]));

        // en dropped mid-pulse for code 3 with 4,5 queued
        in_valid = 1'b1; in_code = 3'd3;
        tick();
        in_code = 3'd4;
        tick();
        chk("e_Y08a", 32'(Y), 32'h08);
        in_code = 3'd5;
        tick();
        in_valid = 1'b0; en = 1'b0;
        chk("e_Y08b", 32'(Y), 32'h08);
        chk("e_cnt2a", 32'(fifo_count), 2);
        repeat (2) tick();
        chk("e_Y08c", 32'(Y), 32'h08);
        tick();
        chk("e_Yend", 32'(Y), 0);
        repeat (5) tick();
        chk("e_park_Y", 32'(Y), 0);
        chk("e_park_yv", 32'(y_valid), 0);
        chk("e_park_cnt", 32'(fifo_count), 2);
        chk("e_park_busy", 32'(busy), 1);
        en = 1'b1;
        tick();
        chk("e_Y10", 32'(Y), 32'h10);
        chk("e_cnt1", 32'(fifo_count), 1);
        repeat (3) tick();
        chk("e_Y10end", 32'(Y), 32'h10);
        repeat (2) begin
            tick();
            chk("e_gap", 32'(Y), 0);
        end
        tick();
        chk("e_Y20", 32'(Y), 32'h20);
        repeat (6) tick();
        chk("e_done", 32'(busy), 0);

        // Flush in cycle 2 of a pulse with a concurrent push
        in_valid = 1'b1; in_code = 3'd6;
        tick();
        in_code = 3'd2;
        tick();
        in_valid = 1'b0;
        chk("f_Y40", 32'(Y), 32'h40);
        tick();
        flush = 1'b1; in_valid = 1'b1; in_code = 3'd3;
        chk("f_rdy", 32'(in_ready), 1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("f_Y", 32'(Y), 0);
        chk("f_yv", 32'(y_valid), 0);
        chk("f_cnt", 32'(fifo_count), 0);
        chk("f_busy", 32'(busy), 0);
        repeat (4) tick();
        chk("f_Yafter", 32'(Y), 0);
        chk("f_cntafter", 32'(fifo_count), 0);

        // GAP=0 instance: codes 1 then 6 back-to-back
        in_valid1 = 1'b1; in_code1 = 3'd1;
        tick();
        in_code1 = 3'd6;
        tick();
        in_valid1 = 1'b0;
        chk("g0_Y02", 32'(Y1), 32'h02);
        repeat (3) begin
            tick();
            chk("g0_Y02h", 32'(Y1), 32'h02);
        end
        repeat (4) begin
            tick();
            chk("g0_Y40", 32'(Y1), 32'h40);
            chk("g0_yv", 32'(y_valid1), 1);
        end
        tick();
        chk("g0_end", 32'(Y1), 0);

        // Asynchronous reset in the middle of a pulse
        in_valid = 1'b1; in_code = 3'd7;
        tick();
        in_code = 3'd1;
        tick();
        in_valid = 1'b0;
        chk("r_Y80", 32'(Y), 32'h80);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("r_Y", 32'(Y), 0);
        chk("r_yv", 32'(y_valid), 0);
        chk("r_cnt", 32'(fifo_count), 0);
        chk("r_rdy", 32'(in_ready), 0);
        chk("r_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        chk("r_rdy_rel", 32'(in_ready), 0);
        tick();
        chk("r_rdy_up", 32'(in_ready), 1);
        chk("r_Y_up", 32'(Y), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
